// File: rtl/servo_trajectory_ramp_if.sv
// ---------------------------------------------------------------------------
// servo_trajectory_ramp_if
// Command port of the servo trajectory ramp. The upstream motion planner
// (master) presents signed target angles with a valid/ready handshake, and
// can pulse home to send all axes back to the home angle.
//   cmd_valid  master->slave  target triple valid
//   cmd_ready  slave->master  ramp block can take a target this cycle
//   cmd_x/y/z  master->slave  signed target angles (degrees)
//   home       master->slave  single-cycle return-to-home request
// ---------------------------------------------------------------------------
interface servo_trajectory_ramp_if #(
  parameter int BIT_SIZE = 11
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic signed [BIT_SIZE-1:0] cmd_x;
  logic signed [BIT_SIZE-1:0] cmd_y;
  logic signed [BIT_SIZE-1:0] cmd_z;
  logic                       home;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_z, home,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_z, home,
    output cmd_ready
  );
endinterface

// File: rtl/servo_trajectory_ramp.sv
// ---------------------------------------------------------------------------
// servo_trajectory_ramp
// Slew-rate limited trajectory stage in front of the PWM servo generator.
// Accepted targets are clamped to [COORD_MIN, COORD_MAX]; the x/y/z angle
// registers then move toward them by at most STEP degrees per ramp tick
// (one tick every FREQ/UPDATE_HZ clocks), so the servos never see a step.
// Ports:
//   clk, rst   clock; asynchronous active-high reset (outputs go HOME)
//   cmd        command port (slave side of servo_trajectory_ramp_if)
//   x, y, z    registered signed current angles
//   busy       high while ramping
//   done       one-cycle pulse in the cycle all axes sit on their targets
// ---------------------------------------------------------------------------

// Per-axis target register, clamp and slew step.
//   load/load_val  latch a new (unclamped) target
//   go_home        retarget to HOME (wins over load)
//   upd            apply one slew step this cycle
//   cur            current angle, at_tgt = (cur == target)
module servo_ramp_axis #(
  parameter int BIT_SIZE  = 11,
  parameter int STEP      = 2,
  parameter int COORD_MIN = -270,
  parameter int COORD_MAX = 270,
  parameter int HOME      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic signed [BIT_SIZE-1:0] load_val,
  input  logic                       go_home,
  input  logic                       upd,
  output logic signed [BIT_SIZE-1:0] cur,
  output logic                       at_tgt
);
  localparam int EW = BIT_SIZE + 2;

  localparam logic signed [BIT_SIZE-1:0] MIN_V  = BIT_SIZE'(COORD_MIN);
  localparam logic signed [BIT_SIZE-1:0] MAX_V  = BIT_SIZE'(COORD_MAX);
  localparam logic signed [BIT_SIZE-1:0] HOME_V = BIT_SIZE'(HOME);
  localparam logic signed [EW-1:0]       STEP_E = EW'(STEP);

  logic signed [BIT_SIZE-1:0] tgt;
  logic signed [BIT_SIZE-1:0] sat_val;
  logic signed [EW-1:0]       cur_e;
  logic signed [EW-1:0]       tgt_e;
  logic signed [EW-1:0]       diff;
  logic signed [EW-1:0]       nxt_e;

  always_comb begin
    sat_val = load_val;
    if (load_val < MIN_V)      sat_val = MIN_V;
    else if (load_val > MAX_V) sat_val = MAX_V;
  end

  // Two guard bits: the difference of two full-range angles cannot wrap.
  always_comb begin
    cur_e = EW'(cur);
    tgt_e = EW'(tgt);
    diff  = tgt_e - cur_e;
    nxt_e = tgt_e;
    if (diff > STEP_E)       nxt_e = cur_e + STEP_E;
    else if (diff < -STEP_E) nxt_e = cur_e - STEP_E;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt <= HOME_V;
    end else if (go_home) begin
      tgt <= HOME_V;
    end else if (load) begin
      tgt <= sat_val;
    end
  end

  // The target is clamped and cur only ever moves toward it, so the
  // truncation back to BIT_SIZE never loses information.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= HOME_V;
    end else if (upd) begin
      cur <= nxt_e[BIT_SIZE-1:0];
    end
  end

  assign at_tgt = (cur == tgt);
endmodule

module servo_trajectory_ramp #(
  parameter int FREQ      = 25_000_000,
  parameter int UPDATE_HZ = 100,
  parameter int STEP      = 2,
  parameter int BIT_SIZE  = 11,
  parameter int COORD_MIN = -270,
  parameter int COORD_MAX = 270,
  parameter int HOME      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  servo_trajectory_ramp_if.slave     cmd,
  output logic signed [BIT_SIZE-1:0] x,
  output logic signed [BIT_SIZE-1:0] y,
  output logic signed [BIT_SIZE-1:0] z,
  output logic                       busy,
  output logic                       done
);
  localparam int NUM_AXES = 3;
  localparam int TICK_DIV = FREQ / UPDATE_HZ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]                        presc;
  logic                                    tick;
  logic                                    accept;
  logic                                    upd;
  logic [NUM_AXES-1:0][BIT_SIZE-1:0]       cmd_vec;
  logic [NUM_AXES-1:0][BIT_SIZE-1:0]       cur_vec;
  logic [NUM_AXES-1:0]                     at_tgt;

  // Free-running ramp prescaler; commands never resynchronise it, so the
  // first step after an accept lands anywhere within one tick period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // home retargets from either state and blocks a same-cycle command.
  // Completion is evaluated every RAMP cycle (not just on ticks), which is
  // what lets a command equal to the current position finish immediately.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd.home) begin
          state_nxt = RAMP;
        end else if (cmd.cmd_valid) begin
          accept    = 1'b1;
          state_nxt = RAMP;
        end
      end
      RAMP: begin
        if (!cmd.home && (&at_tgt)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd.cmd_ready = (state == IDLE) && !cmd.home;
  assign busy          = (state == RAMP);
  assign upd           = tick && (state == RAMP);

  assign cmd_vec[0] = cmd.cmd_x;
  assign cmd_vec[1] = cmd.cmd_y;
  assign cmd_vec[2] = cmd.cmd_z;

  for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
    servo_ramp_axis #(
      .BIT_SIZE  (BIT_SIZE),
      .STEP      (STEP),
      .COORD_MIN (COORD_MIN),
      .COORD_MAX (COORD_MAX),
      .HOME      (HOME)
    ) u_axis (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (cmd_vec[g]),
      .go_home  (cmd.home),
      .upd      (upd),
      .cur      (cur_vec[g]),
      .at_tgt   (at_tgt[g])
    );
  end

  assign x = cur_vec[0];
  assign y = cur_vec[1];
  assign z = cur_vec[2];
endmodule

// File: tb/tb_servo_trajectory_ramp.sv
// Scoreboard bench: stimulus pushes every expected angle triple (one per
// tick that moves an axis, plus reset snapshots) and every expected done
// position; the negedge monitor pops one entry per observed change / done.
module tb_servo_trajectory_ramp;
  localparam int BW   = 11;
  localparam int STEP = 2;

  typedef struct { int x; int y; int z; } pos_t;

  logic clk = 1'b0;
  logic rst;
  logic signed [BW-1:0] x, y, z;
  logic busy, done;

  servo_trajectory_ramp_if #(.BIT_SIZE(BW)) cif();

  servo_trajectory_ramp #(
    .FREQ(1000), .UPDATE_HZ(100), .STEP(STEP), .BIT_SIZE(BW),
    .COORD_MIN(-270), .COORD_MAX(270), .HOME(0)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cif), .x(x), .y(y), .z(z),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  pos_t exp_pos[$];
  pos_t exp_done[$];
  int   px = 0, py = 0, pz = 0;   // model position for trajectory generation

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pos(input string name, input int ax, input int ay,
                           input int az, input pos_t e);
    n_tests++;
    if (ax != e.x || ay != e.y || az != e.z) begin
      n_fail++;
      $display("FAIL %s: got (%0d,%0d,%0d), expected (%0d,%0d,%0d)",
               name, ax, ay, az, e.x, e.y, e.z);
    end
  endtask

  function automatic int sat(input int v);
    if (v < -270) return -270;
    if (v > 270)  return 270;
    return v;
  endfunction

  function automatic int step1(input int c, input int t);
    if (t - c > STEP)  return c + STEP;
    if (t - c < -STEP) return c - STEP;
    return t;
  endfunction

  task automatic push(input int a, input int b, input int c);
    pos_t p;
    p.x = a; p.y = b; p.z = c;
    exp_pos.push_back(p);
  endtask

  task automatic push_done(input int a, input int b, input int c);
    pos_t p;
    p.x = a; p.y = b; p.z = c;
    exp_done.push_back(p);
  endtask

  // Expected per-tick trajectory from the model position to a raw target.
  task automatic push_ramp(input int rx, input int ry, input int rz);
    int tx, ty, tz;
    tx = sat(rx); ty = sat(ry); tz = sat(rz);
    while (px != tx || py != ty || pz != tz) begin
      px = step1(px, tx); py = step1(py, ty); pz = step1(pz, tz);
      push(px, py, pz);
    end
  endtask

  task automatic send_cmd(input int a, input int b, input int c);
    bit ok = 0;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b1;
    cif.cmd_x = BW'(a); cif.cmd_y = BW'(b); cif.cmd_z = BW'(c);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cif.cmd_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send_cmd_timeout: got no cmd_ready, expected ready");
    end
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL %s: got no done within %0d cycles, expected done", name, budget);
    end
  endtask

  task automatic wait_x(input string name, input int v, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(x) == v) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL %s: got x=%0d after %0d cycles, expected %0d", name, x, budget, v);
    end
  endtask

  // Monitor: pops one expected triple per observed output change and one
  // expected done position per done pulse.
  int   lx = 0, ly = 0, lz = 0;
  int   cx, cy, cz;
  bit   changed;
  bit   done_prev = 0;
  pos_t e;

  always @(negedge clk) begin
    cx = int'(x); cy = int'(y); cz = int'(z);
    changed = (cx != lx) || (cy != ly) || (cz != lz);
    if (changed) begin
      if (exp_pos.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_move: got (%0d,%0d,%0d), expected no change from (%0d,%0d,%0d)",
                 cx, cy, cz, lx, ly, lz);
      end else begin
        e = exp_pos.pop_front();
        check_pos("trajectory", cx, cy, cz, e);
      end
    end
    if (done) begin
      if (exp_done.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_done: got done at (%0d,%0d,%0d), expected none", cx, cy, cz);
      end else begin
        e = exp_done.pop_front();
        check_pos("done_position", cx, cy, cz, e);
        check("done_follows_tick", int'(changed), 1);
        check("busy_during_done", int'(busy), 1);
      end
    end
    if (done_prev && !cif.home) begin
      check("busy_after_done", int'(busy), 0);
      check("ready_after_done", int'(cif.cmd_ready), 1);
    end
    done_prev = done;
    lx = cx; ly = cy; lz = cz;
  end

  initial begin
    pos_t zero;
    zero.x = 0; zero.y = 0; zero.z = 0;
    rst = 1'b1;
    cif.cmd_valid = 1'b0; cif.home = 1'b0;
    cif.cmd_x = '0; cif.cmd_y = '0; cif.cmd_z = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state and stillness
    @(negedge clk);
    check_pos("reset_pos", int'(x), int'(y), int'(z), zero);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_ready", int'(cif.cmd_ready), 1);
    repeat (50) @(negedge clk);

    // 2: small ramp, hand-listed trajectory
    push(2, -2, 2); push(4, -4, 3); push(6, -5, 3); push(8, -5, 3); push(10, -5, 3);
    push_done(10, -5, 3);
    px = 10; py = -5; pz = 3;
    send_cmd(10, -5, 3);
    wait_done("t2_done", 200);

    // 3: saturating targets
    push_ramp(500, -1024, 270);
    push_done(270, -270, 270);
    send_cmd(500, -1024, 270);
    wait_done("t3_done", 2000);

    // 4: command held during a ramp is taken only after done
    push_ramp(260, -260, 260);
    push_done(260, -260, 260);
    send_cmd(260, -260, 260);
    cif.cmd_valid = 1'b1;
    cif.cmd_x = BW'(20); cif.cmd_y = BW'(20); cif.cmd_z = BW'(20);
    push_ramp(20, 20, 20);
    push_done(20, 20, 20);
    repeat (3) begin
      @(negedge clk);
      check("t4_ready_in_ramp", int'(cif.cmd_ready), 0);
    end
    wait_done("t4_done_a", 200);
    @(negedge clk);
    check("t4_ready_after_done", int'(cif.cmd_ready), 1);
    @(posedge clk); #1 cif.cmd_valid = 1'b0;
    wait_done("t4_done_b", 2000);

    // 5: home mid-ramp with a competing command
    push_ramp(0, 0, 0);
    push_done(0, 0, 0);
    send_cmd(0, 0, 0);
    wait_done("t5_to_zero", 300);
    for (int i = 1; i <= 8; i++) push(2 * i, 0, 0);
    px = 16; py = 0; pz = 0;
    send_cmd(40, 0, 0);
    wait_x("t5_reach16", 16, 200);
    @(posedge clk); #1;
    cif.home = 1'b1;
    cif.cmd_valid = 1'b1;
    cif.cmd_x = BW'(5); cif.cmd_y = BW'(5); cif.cmd_z = BW'(5);
    push_ramp(0, 0, 0);
    push_done(0, 0, 0);
    @(negedge clk);
    check("t5_ready_on_home", int'(cif.cmd_ready), 0);
    check("t5_busy_on_home", int'(busy), 1);
    @(posedge clk); #1;
    cif.home = 1'b0;
    cif.cmd_valid = 1'b0;
    wait_done("t5_done_home", 300);

    // 6: asynchronous reset mid-ramp
    push(2, 2, 2); push(4, 4, 4);
    send_cmd(30, 30, 30);
    wait_x("t6_reach4", 4, 200);
    @(posedge clk); #3;
    push(0, 0, 0);
    rst = 1'b1;
    #1;
    check_pos("t6_async_pos", int'(x), int'(y), int'(z), zero);
    check("t6_async_busy", int'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    px = 0; py = 0; pz = 0;
    push_ramp(3, -3, 1);
    push_done(3, -3, 1);
    send_cmd(3, -3, 1);
    wait_done("t6_done", 200);

    repeat (20) @(negedge clk);
    check("pos_queue_empty", exp_pos.size(), 0);
    check("done_queue_empty", exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/servo_trajectory_ramp.md
Name: servo_trajectory_ramp

Overview:
Upstream motion stage for the three-servo arm. It accepts target angles (degrees, signed) through a valid/ready command port. It drives registered x/y/z angle outputs that ramp toward the targets at a bounded slew rate, which prevents step jumps in servo position. The x/y/z outputs connect directly to the x/y/z inputs of the PWM servo generator, which maps −270..270 to duty cycle with 0 at centre.

Parameters:
FREQ, 25_000_000, system clock frequency in Hz
UPDATE_HZ, 100, ramp update rate; TICK_DIV = FREQ/UPDATE_HZ clock cycles per tick
STEP, 2, maximum change per axis per tick, in degrees (≥1)
BIT_SIZE, 11, width of signed angle buses
COORD_MIN, -270, lower saturation limit
COORD_MAX, 270, upper saturation limit
HOME, 0, home/reset angle for all axes

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command target valid
cmd_ready  out  1  block can accept a command (combinational)
cmd_x  in  BIT_SIZE  signed target angle, axis 1
cmd_y  in  BIT_SIZE  signed target angle, axis 2
cmd_z  in  BIT_SIZE  signed target angle, axis 3
home  in  1  single-cycle request to ramp all axes to HOME
x  out  BIT_SIZE  signed current angle, axis 1 (registered)
y  out  BIT_SIZE  signed current angle, axis 2 (registered)
z  out  BIT_SIZE  signed current angle, axis 3 (registered)
busy  out  1  high while ramping
done  out  1  single-cycle pulse when all axes reach target

Behaviour:
- Reset (asynchronous, rst=1):
  - x, y, z, and the internal targets tx, ty, tz go to HOME.
  - FSM goes to IDLE; done=0; prescaler=0.
  - Outputs take these values immediately, including when reset is asserted mid-ramp.
- Prescaler:
  - Free-runs 0..TICK_DIV−1 and wraps to 0.
  - tick is high for exactly one cycle when the count equals TICK_DIV−1, then every TICK_DIV cycles.
  - The prescaler is never restarted by commands.
- FSM states: IDLE and RAMP. busy = (state==RAMP).
- cmd_ready = (state==IDLE) & ~home.
- Accept:
  - Condition: cmd_valid & cmd_ready on a rising edge.
  - Action: each cmd_* is saturated to [COORD_MIN, COORD_MAX] and stored in the matching t*; state goes to RAMP.
  - A command is never accepted while in RAMP. The upstream side holds cmd_valid and its data until ready.
- home:
  - In any state, a high home sets tx=ty=tz=HOME and state goes to RAMP. This retargets an in-progress ramp; current x/y/z are kept.
  - home has priority over cmd_valid in the same cycle; that command is not accepted.
- Ramp update (state==RAMP, on tick cycles only), per axis, with d = t − cur:
  - |d| ≤ STEP: cur ← t.
  - d > STEP: cur ← cur + STEP.
  - d < −STEP: cur ← cur − STEP.
  - Compute at BIT_SIZE+2 signed width so no overflow can occur.
  - Axes are independent; an axis that has already arrived holds its value.
- Completion:
  - Condition: in RAMP, any cycle where x==tx, y==ty and z==tz, and home is low.
  - Action: state goes to IDLE and done=1 for that one cycle.
  - Consequence: done rises one cycle after the final tick update, and cmd_ready returns the cycle after that.
- Null command: a command equal to the current position gives RAMP for one cycle, then a done pulse, with no tick needed.
- Output stability: x/y/z change only on tick cycles (or reset), so they are always within [COORD_MIN, COORD_MAX].

Test Plan:
(Parameters for all cases: FREQ=1000, UPDATE_HZ=100 (TICK_DIV=10), STEP=2.)
1. Reset release → x=y=z=0, busy=0, done=0, cmd_ready=1; outputs stay constant for 50 cycles with no command.
2. Command (10,−5,3) accepted → over successive ticks x: 2,4,6,8,10; y: −2,−4,−5; z: 2,3. Exactly one done pulse follows the 5th tick; busy falls with it; cmd_ready is 1 the next cycle.
3. Command (500, −1024, 270) → targets saturate to (270, −270, 270); after ramping, final x=270, y=−270, z=270; no output ever exceeds ±270.
4. cmd_valid held high with (20,20,20) during an active ramp → cmd_ready=0 and targets are unchanged until done. The held command is then accepted the cycle after done, and a new ramp reaches 20.
5. home pulse mid-ramp toward (40,0,0) at x=16 → cmd_ready=0 that cycle and a simultaneous cmd_valid is ignored. x ramps 14,12,…,0; done pulses once, only at HOME.
6. rst asserted asynchronously mid-ramp between clock edges → x=y=z=0 and busy=0 immediately. After release, the next accepted command ramps from 0.
